rr_sel_sequencer: RTL and testbench

Registered round-robin select generator that drives the S1/S0 select inputs of the 2:4 decoder in the tri-state 1x4 mux path. It arbitrates four channel requests, holds one owner's select stable for a bounded dwell time, and inserts a one-cycle break-before-make gap on every owner change. The gap keeps the decoder-enabled tri-state drivers from overlapping during a switch.

---
 rtl/rr_sel_pkg.sv | 18 +
 rtl/rr_sel_sequencer_if.sv | 29 ++
 rtl/rr_pick4.sv | 30 +++
 rtl/rr_sel_sequencer.sv | 77 +++++++
 tb/tb_rr_sel_sequencer.sv | 134 +++++++++++++
 5 files changed

// File: rtl/rr_sel_pkg.sv
// rtl/rr_sel_pkg.sv - shared types and constants for the round-robin select sequencer
package rr_sel_pkg;

  localparam int NUM_CH = 4;

  typedef logic [1:0] ch_idx_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_e;

  function automatic logic [NUM_CH-1:0] ch_onehot(input ch_idx_t ch);
    return NUM_CH'(1) << ch;
  endfunction

endpackage

// File: rtl/rr_sel_sequencer_if.sv
// rtl/rr_sel_sequencer_if.sv - request/dwell inputs and decoder select outputs
interface rr_sel_sequencer_if #(
  parameter int DWELL_W = 4
);
  import rr_sel_pkg::*;

  logic [NUM_CH-1:0]  req;
  logic [DWELL_W-1:0] dwell;
  logic               S1;
  logic               S0;
  logic               sel_valid;

  modport master (
    output req,
    output dwell,
    input  S1,
    input  S0,
    input  sel_valid
  );

  modport slave (
    input  req,
    input  dwell,
    output S1,
    output S0,
    output sel_valid
  );

endinterface

// File: rtl/rr_pick4.sv
// rtl/rr_pick4.sv - combinational round-robin pick over four channels
// Search begins one past last_owner and wraps; reaching last_owner itself is the final candidate.
module rr_pick4
  import rr_sel_pkg::*;
(
  input  logic [NUM_CH-1:0] req,
  input  ch_idx_t           last_owner,
  output ch_idx_t           pick,
  output logic              any_req
);

  ch_idx_t cand;
  logic    found;

  always_comb begin
    pick  = last_owner;
    found = 1'b0;
    cand  = last_owner;
    for (int i = 1; i <= NUM_CH; i++) begin
      cand = ch_idx_t'(last_owner + ch_idx_t'(i));
      if (!found && req[cand]) begin
        pick  = cand;
        found = 1'b1;
      end
    end
  end

  assign any_req = |req;

endmodule

// File: rtl/rr_sel_sequencer.sv
// rtl/rr_sel_sequencer.sv - registered round-robin S1/S0 generator with dwell limit and break-before-make gap
module rr_sel_sequencer
  import rr_sel_pkg::*;
#(
  parameter int DWELL_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  rr_sel_sequencer_if.slave  bus
);

  localparam logic [1:0] ST_IDLE  = IDLE;
  localparam logic [1:0] ST_GRANT = GRANT;
  localparam logic [1:0] ST_GAP   = GAP;

  logic [1:0]         state;
  logic [1:0]         state_nxt;
  ch_idx_t            owner;
  ch_idx_t            last_owner;
  ch_idx_t            pick;
  logic               any_req;
  logic               others_req;
  logic               released;
  logic               expired;
  logic               preempt;
  logic [DWELL_W-1:0] dwell_cnt;
  logic               sel_valid_q;

  rr_pick4 u_pick (
    .req        (bus.req),
    .last_owner (last_owner),
    .pick       (pick),
    .any_req    (any_req)
  );

  // Counter counts down to 1 and parks there; a load of 0 never reaches 1, so dwell=0 is unlimited.
  assign others_req = |(bus.req & ~ch_onehot(owner));
  assign released   = !bus.req[owner];
  assign expired    = (dwell_cnt == DWELL_W'(1));
  assign preempt    = expired && others_req;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (any_req) state_nxt = ST_GRANT;
      ST_GRANT: if (released || preempt) state_nxt = ST_GAP;
      ST_GAP:   state_nxt = any_req ? ST_GRANT : ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Owner and dwell are captured only on entry to GRANT, so the select never moves while valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      owner       <= '0;
      last_owner  <= ch_idx_t'(NUM_CH - 1);
      dwell_cnt   <= '0;
      sel_valid_q <= 1'b0;
    end else begin
      state       <= state_nxt;
      sel_valid_q <= (state_nxt == ST_GRANT);
      if (state != ST_GRANT && state_nxt == ST_GRANT) begin
        owner      <= pick;
        last_owner <= pick;
        dwell_cnt  <= bus.dwell;
      end else if (state == ST_GRANT && dwell_cnt > DWELL_W'(1)) begin
        dwell_cnt <= dwell_cnt - DWELL_W'(1);
      end
    end
  end

  assign bus.S1        = owner[1];
  assign bus.S0        = owner[0];
  assign bus.sel_valid = sel_valid_q;

endmodule

// File: tb/tb_rr_sel_sequencer.sv
// tb/tb_rr_sel_sequencer.sv - directed vector bench for rr_sel_sequencer
module tb_rr_sel_sequencer;

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic [3:0] dwell;
    logic [1:0] sel;
    logic       valid;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  rr_sel_sequencer_if #(.DWELL_W(4)) bus ();

  rr_sel_sequencer #(.DWELL_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic add(input logic rst, input logic [3:0] req, input logic [3:0] dw,
                     input logic [1:0] sel, input logic valid, input int n = 1);
    vec_t t;
    t.rst = rst; t.req = req; t.dwell = dw; t.sel = sel; t.valid = valid;
    for (int i = 0; i < n; i++) vecs.push_back(t);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    bus.req   = 4'h0;
    bus.dwell = 4'h0;

    // single requester, unlimited dwell, then release
    add(1, 4'b0000, 0, 2'b00, 0);
    add(0, 4'b0001, 0, 2'b00, 1);
    add(0, 4'b0001, 0, 2'b00, 1, 10);
    add(0, 4'b0000, 0, 2'b00, 0);
    add(0, 4'b0000, 0, 2'b00, 0);
    // two requesters, dwell=3
    add(1, 4'b0000, 0, 2'b00, 0);
    add(0, 4'b0101, 3, 2'b00, 1, 3);
    add(0, 4'b0101, 3, 2'b00, 0);
    add(0, 4'b0101, 3, 2'b10, 1, 3);
    add(0, 4'b0101, 3, 2'b10, 0);
    add(0, 4'b0101, 3, 2'b00, 1, 3);
    add(0, 4'b0101, 3, 2'b00, 0);
    // all requesting, dwell=1, wrap 3 -> 0
    add(1, 4'b0000, 0, 2'b00, 0);
    add(0, 4'b1111, 1, 2'b00, 1); add(0, 4'b1111, 1, 2'b00, 0);
    add(0, 4'b1111, 1, 2'b01, 1); add(0, 4'b1111, 1, 2'b01, 0);
    add(0, 4'b1111, 1, 2'b10, 1); add(0, 4'b1111, 1, 2'b10, 0);
    add(0, 4'b1111, 1, 2'b11, 1); add(0, 4'b1111, 1, 2'b11, 0);
    add(0, 4'b1111, 1, 2'b00, 1);
    // lone ch1 held past expiry, then ch3 arrives
    add(1, 4'b0000, 0, 2'b00, 0);
    add(0, 4'b0010, 2, 2'b01, 1, 7);
    add(0, 4'b1010, 2, 2'b01, 0);
    add(0, 4'b1010, 2, 2'b11, 1, 2);
    add(0, 4'b1010, 2, 2'b11, 0);
    add(0, 4'b1010, 2, 2'b01, 1);
    // ch1 drops during GAP: ch0 re-picked, held past expiry, then release to IDLE
    add(1, 4'b0000, 0, 2'b00, 0);
    add(0, 4'b0011, 1, 2'b00, 1);
    add(0, 4'b0011, 1, 2'b00, 0);
    add(0, 4'b0001, 1, 2'b00, 1, 2);
    add(0, 4'b0000, 1, 2'b00, 0, 2);
    // release coincides with expiry
    add(1, 4'b0000, 0, 2'b00, 0);
    add(0, 4'b0011, 1, 2'b00, 1);
    add(0, 4'b0010, 1, 2'b00, 0);
    add(0, 4'b0010, 1, 2'b01, 1);
    // dwell sampled only at grant start
    add(1, 4'b0000, 0, 2'b00, 0);
    add(0, 4'b0011, 2, 2'b00, 1);
    add(0, 4'b0011, 0, 2'b00, 1);
    add(0, 4'b0011, 0, 2'b00, 0);
    add(0, 4'b0011, 0, 2'b01, 1);

    @(negedge clk);
    check("reset_sel", {bus.S1, bus.S0}, 2'b00);
    check("reset_valid", bus.sel_valid, 1'b0);

    for (int i = 0; i < vecs.size(); i++) begin
      rst_n     = vecs[i].rst ? 1'b0 : 1'b1;
      bus.req   = vecs[i].req;
      bus.dwell = vecs[i].dwell;
      @(posedge clk);
      @(negedge clk);
      check($sformatf("vec%0d_sel", i), {bus.S1, bus.S0}, vecs[i].sel);
      check($sformatf("vec%0d_valid", i), bus.sel_valid, vecs[i].valid);
    end

    // asynchronous reset in the middle of a ch2 grant
    rst_n     = 1'b0;
    bus.req   = 4'b0100;
    bus.dwell = 4'h0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); @(negedge clk);
    check("ch2_grant_sel", {bus.S1, bus.S0}, 2'b10);
    check("ch2_grant_valid", bus.sel_valid, 1'b1);
    @(posedge clk); @(negedge clk);
    check("ch2_hold_valid", bus.sel_valid, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_valid", bus.sel_valid, 1'b0);
    check("async_rst_sel", {bus.S1, bus.S0}, 2'b00);
    bus.req = 4'b1100;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); @(negedge clk);
    check("post_rst_sel", {bus.S1, bus.S0}, 2'b10);
    check("post_rst_valid", bus.sel_valid, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
